// File: rtl/stream_fifo.sv
// stream_fifo: parametrised valid/ready FIFO with selectable first-word-fall-through or
// registered output, occupancy count, almost-full/almost-empty flags and synchronous flush.
module stream_fifo #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FWFT      = 1,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] Full    = CW'(DEPTH);
    localparam logic [CW-1:0] AfLvl   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeLvl   = CW'(AE_THRESH);
    localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be at least 2");
    end
    if (AF_THRESH > DEPTH) begin : g_bad_af
        $error("stream_fifo: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("stream_fifo: AE_THRESH must be below DEPTH");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    // Output register, only active when FWFT == 0.
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] od_q, od_d;

    logic push, pop, rd_en, wr_en, load, st_empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + PW'(1);
    endfunction

    // Handshake and visible head entry.
    always_comb begin
        in_ready     = (count_q < Full) && !flush && !reset;
        out_valid    = (FWFT != 0) ? (count_q != '0) : ov_q;
        out_data     = (FWFT != 0) ? ((count_q != '0) ? mem_q[rptr_q] : '0) : od_q;
        push         = in_valid && in_ready;
        pop          = out_valid && out_ready;
        count        = count_q;
        almost_full  = (count_q >= AfLvl);
        almost_empty = (count_q <= AeLvl);
    end

    // Next-state: storage access, output-register refill, pointers and count.
    always_comb begin
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        load    = 1'b0;
        ov_d    = ov_q;
        od_d    = od_q;
        // Entries in storage exclude the one parked in the output register.
        st_empty = (count_q == CW'(ov_q));

        if (FWFT != 0) begin
            rd_en = pop;
            wr_en = push;
        end else begin
            load = !ov_q || pop;
            if (load) begin
                if (!st_empty) begin
                    rd_en = 1'b1;
                    ov_d  = 1'b1;
                    od_d  = mem_q[rptr_q];
                    wr_en = push;
                end else if (push && ov_q) begin
                    // Head leaves while storage is empty: new word goes straight to the
                    // output register so a one-deep stream keeps full throughput.
                    ov_d = 1'b1;
                    od_d = in_data;
                end else begin
                    ov_d  = 1'b0;
                    wr_en = push;
                end
            end else begin
                wr_en = push;
            end
        end

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wptr_q] = in_data;
        end
        wptr_d = wr_en ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = rd_en ? ptr_inc(rptr_q) : rptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            ov_d    = 1'b0;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Testbench for stream_fifo: four configurations share one stimulus stream and are
// checked against a queue-based reference model, a vector table and directed sequences.
module tb_stream_fifo;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, flush, in_valid, out_ready;
    logic [W-1:0] in_data;

    logic [3:0]   d_cnt [4];
    logic         d_ird [4];
    logic         d_ov  [4];
    logic         d_af  [4];
    logic         d_ae  [4];
    logic [W-1:0] d_od  [4];
    logic [3:0]   cnt0, cnt1;
    logic [2:0]   cnt2, cnt3;

    assign d_cnt[0] = cnt0;
    assign d_cnt[1] = cnt1;
    assign d_cnt[2] = {1'b0, cnt2};
    assign d_cnt[3] = {1'b0, cnt3};

    stream_fifo #(.WIDTH(W), .DEPTH(8), .FWFT(1)) u0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d_ird[0]),
        .in_data(in_data), .out_valid(d_ov[0]), .out_ready(out_ready), .out_data(d_od[0]),
        .count(cnt0), .almost_full(d_af[0]), .almost_empty(d_ae[0]));
    stream_fifo #(.WIDTH(W), .DEPTH(8), .FWFT(0)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d_ird[1]),
        .in_data(in_data), .out_valid(d_ov[1]), .out_ready(out_ready), .out_data(d_od[1]),
        .count(cnt1), .almost_full(d_af[1]), .almost_empty(d_ae[1]));
    stream_fifo #(.WIDTH(W), .DEPTH(5), .FWFT(1)) u2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d_ird[2]),
        .in_data(in_data), .out_valid(d_ov[2]), .out_ready(out_ready), .out_data(d_od[2]),
        .count(cnt2), .almost_full(d_af[2]), .almost_empty(d_ae[2]));
    stream_fifo #(.WIDTH(W), .DEPTH(5), .FWFT(0), .AF_THRESH(4), .AE_THRESH(2)) u3 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d_ird[3]),
        .in_data(in_data), .out_valid(d_ov[3]), .out_ready(out_ready), .out_data(d_od[3]),
        .count(cnt3), .almost_full(d_af[3]), .almost_empty(d_ae[3]));

    // Reference model: per-instance queue of held entries. In registered-output mode a
    // word pushed into a completely empty FIFO stays invisible for one extra cycle.
    int m_depth [4] = '{8, 8, 5, 5};
    int m_fwft  [4] = '{1, 0, 1, 0};
    int m_af    [4] = '{6, 6, 3, 4};
    int m_ae    [4] = '{1, 1, 1, 2};
    logic [W-1:0] mq  [4][$];
    logic [W-1:0] got [4][$];
    bit           mfresh [4];

    int checks = 0;
    int errors = 0;

    function automatic bit m_ov(int i);
        return (mq[i].size() > 0) && !(m_fwft[i] == 0 && mfresh[i]);
    endfunction

    function automatic bit m_ird(int i);
        return (mq[i].size() < m_depth[i]) && !flush && !reset;
    endfunction

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got=%0h exp=%0h", name, i, act, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 4; i++) begin
            bit p_push, p_pop, was_empty;
            p_push = in_valid && m_ird(i);
            p_pop  = m_ov(i) && out_ready;
            if (reset || flush) begin
                mq[i].delete();
                mfresh[i] = 1'b0;
            end else begin
                was_empty = (mq[i].size() == 0);
                if (p_pop) void'(mq[i].pop_front());
                if (p_push) mq[i].push_back(in_data);
                mfresh[i] = p_push && was_empty;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("count", i, 32'(d_cnt[i]), 32'(mq[i].size()));
            chk("out_valid", i, 32'(d_ov[i]), 32'(m_ov(i)));
            if (m_ov(i)) chk("out_data", i, 32'(d_od[i]), 32'(mq[i][0]));
            chk("in_ready", i, 32'(d_ird[i]), 32'(m_ird(i)));
            chk("almost_full", i, 32'(d_af[i]), 32'(mq[i].size() >= m_af[i]));
            chk("almost_empty", i, 32'(d_ae[i]), 32'(mq[i].size() <= m_ae[i]));
        end
    endtask

    // One clock: log DUT pops, take the edge, update model, compare on the falling edge.
    task automatic cycle();
        #1;
        for (int i = 0; i < 4; i++) begin
            if (d_ov[i] === 1'b1 && out_ready) got[i].push_back(d_od[i]);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(bit r, bit f, bit iv, logic [W-1:0] d, bit ordy);
        reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 8'h00, 0);
        cycle();
        drive(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) got[i].delete();
    endtask

    typedef struct {
        bit           rst;
        bit           iv;
        logic [W-1:0] d;
        bit           ordy;
        int           c0;
        bit           v0;
        logic [W-1:0] o0;
        int           c1;
        bit           v1;
        logic [W-1:0] o1;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // Expected state after each edge for inst0 (FWFT) and inst1 (registered).
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'hA1, 1'b0, 1, 1'b1, 8'hA1, 1, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b1, 8'hA1, 1, 1'b1, 8'hA1};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b1, 8'hA1, 1, 1'b1, 8'hA1};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b1, 8'hA1, 1, 1'b1, 8'hA1};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 1'b1, 8'h55, 1'b0, 1, 1'b1, 8'h55, 1, 1'b0, 8'h00};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h55, 1, 1'b1, 8'h55};

        for (int r = 0; r < 8; r++) begin
            drive(tbl[r].rst, 0, tbl[r].iv, tbl[r].d, tbl[r].ordy);
            cycle();
            chk("tbl_count", 0, 32'(d_cnt[0]), 32'(tbl[r].c0));
            chk("tbl_valid", 0, 32'(d_ov[0]), 32'(tbl[r].v0));
            if (tbl[r].v0 || tbl[r].rst) chk("tbl_data", 0, 32'(d_od[0]), 32'(tbl[r].o0));
            chk("tbl_count", 1, 32'(d_cnt[1]), 32'(tbl[r].c1));
            chk("tbl_valid", 1, 32'(d_ov[1]), 32'(tbl[r].v1));
            if (tbl[r].v1 || tbl[r].rst) chk("tbl_data", 1, 32'(d_od[1]), 32'(tbl[r].o1));
            if (r == 1) chk("tbl_almost_empty", 0, 32'(d_ae[0]), 32'd1);
        end

        // Continuous stream behind a single held word: no bubbles, order kept.
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 1, 8'(8'h10 + k), 1);
            cycle();
            chk("stream_valid", 1, 32'(d_ov[1]), 32'd1);
            chk("stream_data", 1, 32'(d_od[1]), 32'(8'h10 + k));
            chk("stream_count", 1, 32'(d_cnt[1]), 32'd1);
        end
        drive(0, 0, 0, 8'h00, 1);
        repeat (3) cycle();

        // Non-power-of-two depth: fill, pop while full, wrap the pointers.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 1, 8'(k), 0);
            cycle();
        end
        chk("full_count", 2, 32'(d_cnt[2]), 32'd5);
        chk("full_ready", 2, 32'(d_ird[2]), 32'd0);
        chk("full_af", 2, 32'(d_af[2]), 32'd1);
        chk("full_count", 3, 32'(d_cnt[3]), 32'd5);
        chk("full_ready", 3, 32'(d_ird[3]), 32'd0);
        drive(0, 0, 1, 8'hEE, 1);
        cycle();
        chk("full_pop_count", 2, 32'(d_cnt[2]), 32'd4);
        chk("full_pop_count", 3, 32'(d_cnt[3]), 32'd4);
        drive(0, 0, 1, 8'd6, 1);
        cycle();
        drive(0, 0, 1, 8'd7, 1);
        cycle();
        drive(0, 0, 0, 8'h00, 1);
        repeat (6) cycle();
        for (int i = 2; i < 4; i++) begin
            chk("wrap_len", i, 32'(got[i].size()), 32'd7);
            for (int k = 0; k < 7 && k < got[i].size(); k++)
                chk("wrap_order", i, 32'(got[i][k]), 32'(k + 1));
        end

        // Concurrent push and pop at count 3.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 8'(8'h20 + k), 0);
            cycle();
        end
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 1, 8'(8'h30 + k), 1);
            cycle();
            for (int i = 0; i < 4; i++) chk("steady_count", i, 32'(d_cnt[i]), 32'd3);
        end
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 10 && k < got[i].size(); k++)
                chk("steady_order", i, 32'(got[i][k]),
                    32'((k < 3) ? (8'h20 + k) : (8'h30 + k - 3)));

        // Flush with a simultaneous push attempt.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 1, 8'(8'h40 + k), 0);
            cycle();
        end
        chk("pre_flush_count", 0, 32'(d_cnt[0]), 32'd6);
        drive(0, 1, 1, 8'h77, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("flush_count", i, 32'(d_cnt[i]), 32'd0);
            chk("flush_valid", i, 32'(d_ov[i]), 32'd0);
            chk("flush_ae", i, 32'(d_ae[i]), 32'd1);
        end
        drive(0, 0, 1, 8'h99, 0);
        cycle();
        for (int i = 0; i < 4; i++) got[i].delete();
        drive(0, 0, 0, 8'h00, 1);
        repeat (4) cycle();
        for (int i = 0; i < 4; i++) begin
            chk("flush_first_len", i, 32'(got[i].size()), 32'd1);
            if (got[i].size() > 0) chk("flush_first", i, 32'(got[i][0]), 32'h99);
        end

        // Reset mid-stream at count 4.
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, 8'(8'h60 + k), 0);
            cycle();
        end
        chk("pre_reset_count", 1, 32'(d_cnt[1]), 32'd4);
        drive(1, 0, 1, 8'hAB, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("reset_count", i, 32'(d_cnt[i]), 32'd0);
            chk("reset_valid", i, 32'(d_ov[i]), 32'd0);
            chk("reset_data", i, 32'(d_od[i]), 32'd0);
            chk("reset_ready_low", i, 32'(d_ird[i]), 32'd0);
        end
        drive(0, 0, 0, 8'h00, 1);
        #1;
        for (int i = 0; i < 4; i++) chk("reset_ready_high", i, 32'(d_ird[i]), 32'd1);
        repeat (2) begin
            cycle();
            for (int i = 0; i < 4; i++) begin
                chk("no_stale_valid", i, 32'(d_ov[i]), 32'd0);
                chk("no_stale_data", i, 32'(d_od[i]), 32'd0);
            end
        end

        // Randomized traffic with alternating back-pressure bias.
        for (int n = 0; n < 3000; n++) begin
            int bias;
            bias = ((n / 200) % 2 == 1) ? 3 : 1;
            drive($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) < bias);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
